// File: rtl/detect_share_sched_pkg.sv
// Shared types, defaults and width helpers for the shared zero/one detect scheduler.
package detect_sched_pkg;

    localparam int unsigned DEF_NEED_ZEROS = 2;
    localparam int unsigned DEF_NEED_ONES  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Width able to hold a frame length of 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width of a counter saturating at n (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/detect_share_sched_zero_one_tracker.sv
// Serial detector: saturating zero/one counters with a sticky hit and the index where it first rose.
module zero_one_tracker
    import detect_sched_pkg::*;
#(
    parameter int unsigned NEED_ZEROS = DEF_NEED_ZEROS,
    parameter int unsigned NEED_ONES  = DEF_NEED_ONES,
    parameter int unsigned IDXW       = 5
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            clr,
    input  logic            en,
    input  logic            bit_in,
    input  logic [IDXW-1:0] idx,
    output logic            hit,
    output logic [IDXW-1:0] hit_pos
);

    localparam int unsigned ZW = cnt_width(NEED_ZEROS);
    localparam int unsigned OW = cnt_width(NEED_ONES);
    localparam logic [ZW-1:0] ZSAT = ZW'(NEED_ZEROS);
    localparam logic [OW-1:0] OSAT = OW'(NEED_ONES);

    logic [ZW-1:0]   zeros_q, zeros_d;
    logic [OW-1:0]   ones_q,  ones_d;
    logic            hit_q,   hit_d;
    logic [IDXW-1:0] pos_q,   pos_d;

    // Next-state: clear wins over a new bit; thresholds are tested with the new bit included.
    always_comb begin
        zeros_d = zeros_q;
        ones_d  = ones_q;
        hit_d   = hit_q;
        pos_d   = pos_q;
        if (clr) begin
            zeros_d = '0;
            ones_d  = '0;
            hit_d   = 1'b0;
            pos_d   = '0;
        end else if (en) begin
            if (bit_in) begin
                if (ones_q < OSAT) ones_d = ones_q + 1'b1;
            end else begin
                if (zeros_q < ZSAT) zeros_d = zeros_q + 1'b1;
            end
            if (!hit_q && (zeros_d >= ZSAT) && (ones_d >= OSAT)) begin
                hit_d = 1'b1;
                pos_d = idx;
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            zeros_q <= '0;
            ones_q  <= '0;
            hit_q   <= 1'b0;
            pos_q   <= '0;
        end else begin
            zeros_q <= zeros_d;
            ones_q  <= ones_d;
            hit_q   <= hit_d;
            pos_q   <= pos_d;
        end
    end

    assign hit     = hit_q;
    assign hit_pos = pos_q;

endmodule

// File: rtl/detect_share_sched.sv
// Round-robin scheduler feeding one requester frame at a time, LSB first, through a shared zero/one detector.
module detect_share_sched
    import detect_sched_pkg::*;
#(
    parameter  int unsigned NREQ       = 4,
    parameter  int unsigned MAX_LEN    = 16,
    parameter  int unsigned NEED_ZEROS = DEF_NEED_ZEROS,
    parameter  int unsigned NEED_ONES  = DEF_NEED_ONES,
    localparam int unsigned LENW       = len_width(MAX_LEN)
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*MAX_LEN-1:0] req_data,
    input  logic [NREQ*LENW-1:0]    req_len,
    output logic                    busy,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic                    hit,
    output logic [LENW-1:0]         hit_pos
);

    localparam int unsigned PW = $clog2(NREQ);

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q,   ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [MAX_LEN-1:0]   frame_q, frame_d;
    logic [LENW-1:0]      len_q,   len_d;
    logic [LENW-1:0]      cnt_q,   cnt_d;

    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic [LENW-1:0]      win_len_raw;
    logic [LENW-1:0]      win_len;
    logic                 det_hit;
    logic [LENW-1:0]      det_pos;

    // Arbiter: first asserted request at or after the pointer, wrapping around.
    always_comb begin : arb
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    assign win_len_raw = req_len[32'(win_idx)*LENW +: LENW];
    assign win_len     = (win_len_raw > LENW'(MAX_LEN)) ? LENW'(MAX_LEN) : win_len_raw;

    // FSM and datapath next-state: latch winner in IDLE, shift exactly len bits, report for one cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        frame_d = frame_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    frame_d = req_data[32'(win_idx)*MAX_LEN +: MAX_LEN];
                    len_d   = win_len;
                    cnt_d   = '0;
                    state_d = (win_len == '0) ? REPORT : SHIFT;
                end
            end
            SHIFT: begin
                frame_d = frame_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_d == len_q) state_d = REPORT;
            end
            REPORT: begin
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            frame_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            frame_q <= frame_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Detector is held clear while idle so every frame starts fresh.
    zero_one_tracker #(
        .NEED_ZEROS (NEED_ZEROS),
        .NEED_ONES  (NEED_ONES),
        .IDXW       (LENW)
    ) u_tracker (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .clr     (state_q == IDLE),
        .en      (state_q == SHIFT),
        .bit_in  (frame_q[0]),
        .idx     (cnt_q),
        .hit     (det_hit),
        .hit_pos (det_pos)
    );

    assign busy    = (state_q != IDLE);
    assign grant   = busy ? (NREQ'(1) << owner_q) : '0;
    assign ack     = (state_q == REPORT) ? grant : '0;
    assign hit     = (state_q == REPORT) && det_hit;
    assign hit_pos = (state_q == REPORT) ? det_pos : '0;

endmodule

// File: tb/tb_detect_share_sched.sv
// Randomised bench for detect_share_sched against a frame-level reference model.
module tb_detect_share_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LENW    = 5;
    localparam int unsigned NZ      = 2;
    localparam int unsigned NO      = 2;

    logic                    Clock = 1'b0;
    logic                    Resetn;
    logic [NREQ-1:0]         req;
    logic [NREQ*MAX_LEN-1:0] req_data;
    logic [NREQ*LENW-1:0]    req_len;
    logic                    busy;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         ack;
    logic                    hit;
    logic [LENW-1:0]         hit_pos;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned m_ptr = 0;

    always #5 Clock = ~Clock;

    detect_share_sched #(
        .NREQ       (NREQ),
        .MAX_LEN    (MAX_LEN),
        .NEED_ZEROS (NZ),
        .NEED_ONES  (NO)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .req      (req),
        .req_data (req_data),
        .req_len  (req_len),
        .busy     (busy),
        .grant    (grant),
        .ack      (ack),
        .hit      (hit),
        .hit_pos  (hit_pos)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int unsigned i, input logic [MAX_LEN-1:0] d, input int unsigned len);
        req_data[i*MAX_LEN +: MAX_LEN] = d;
        req_len[i*LENW +: LENW]        = LENW'(len);
    endtask

    // Reference winner: first set request scanning up from the model pointer.
    function automatic int unsigned m_pick(input logic [NREQ-1:0] r);
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return 0;
    endfunction

    // Reference detector: plain running counts over the first n bits.
    function automatic void exp_detect(input logic [MAX_LEN-1:0] d, input int unsigned n,
                                       output bit h, output int unsigned pos);
        int unsigned z = 0;
        int unsigned o = 0;
        h   = 1'b0;
        pos = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (d[i]) o++;
            else      z++;
            if (!h && z >= NZ && o >= NO) begin
                h   = 1'b1;
                pos = i;
            end
        end
    endfunction

    // Called at a negedge with the DUT idle and req != 0; the next posedge samples.
    task automatic serve(input string tag, input bit scramble);
        int unsigned w, n, epos;
        bit eh, got_ack;
        logic [MAX_LEN-1:0] d;
        logic [NREQ-1:0] g;
        chk({tag, ":idle_busy"}, busy, 0);
        w = m_pick(req);
        d = req_data[w*MAX_LEN +: MAX_LEN];
        n = req_len[w*LENW +: LENW];
        if (n > MAX_LEN) n = MAX_LEN;
        exp_detect(d, n, eh, epos);
        g = '0;
        g[w] = 1'b1;
        got_ack = 1'b0;
        for (int unsigned c = 1; c <= 40 && !got_ack; c++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (scramble && c == 1) begin
                req_data = {$urandom, $urandom};
                req_len  = (NREQ*LENW)'($urandom);
                if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
            end
            chk({tag, ":grant"}, grant, g);
            chk({tag, ":busy"}, busy, 1);
            if (ack != '0) begin
                got_ack = 1'b1;
                chk({tag, ":ack"}, ack, g);
                chk({tag, ":latency"}, c, n + 1);
                chk({tag, ":hit"}, hit, eh);
                chk({tag, ":hit_pos"}, hit_pos, epos);
                req[w] = 1'b0;
            end
        end
        if (!got_ack) chk({tag, ":ack_timeout"}, 0, 1);
        m_ptr = (w + 1) % NREQ;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn   = 1'b0;
        req      = '0;
        req_data = '0;
        req_len  = '0;
        repeat (2) @(negedge Clock);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_hit", hit, 0);
        chk("rst_hit_pos", hit_pos, 0);
        Resetn = 1'b1;
        @(negedge Clock);

        // bits 0,1,1,1,0,1
        set_slot(0, 16'b0000_0000_0010_1110, 6);
        req = 4'b0001;
        serve("t1", 1'b0);

        set_slot(1, 16'hFFFF, 8);
        req = 4'b0010;
        serve("t2", 1'b0);

        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        m_ptr  = 0;
        for (int unsigned i = 0; i < NREQ; i++) set_slot(i, 16'($urandom), $urandom_range(0, 18));
        req = 4'b1111;
        for (int unsigned i = 0; i < NREQ; i++) serve("t3a", 1'b0);
        req = 4'b0101;
        serve("t3b", 1'b0);
        serve("t3b", 1'b0);

        set_slot(2, 16'($urandom), 0);
        req = 4'b0100;
        serve("t4", 1'b0);

        // low nibble 0,0,1,1 then random; length 20 clamps to 16
        set_slot(3, {12'($urandom), 4'b1100}, 20);
        req = 4'b1000;
        serve("t5", 1'b0);

        set_slot(3, 16'hFFFF, 10);
        req = 4'b1000;
        @(posedge Clock);
        repeat (3) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant, 0);
        chk("t6_ack", ack, 0);
        chk("t6_hit", hit, 0);
        chk("t6_hit_pos", hit_pos, 0);
        set_slot(1, 16'b0000_0000_0000_1100, 4);
        req = 4'b1010;
        @(negedge Clock);
        chk("t6_ack_in_rst", ack, 0);
        Resetn = 1'b1;
        m_ptr  = 0;
        serve("t6", 1'b0);
        serve("t6b", 1'b0);

        for (int unsigned it = 0; it < 150; it++) begin
            if (req == '0 || $urandom_range(0, 3) == 0) begin
                req      = req | NREQ'($urandom_range(1, 15));
                req_data = {$urandom, $urandom};
                for (int unsigned i = 0; i < NREQ; i++) req_len[i*LENW +: LENW] = LENW'($urandom_range(0, 20));
            end
            serve("rnd", $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
